// File: rtl/wakeup_matrix_sched_pkg.sv
// Shared types, constants and helpers for the wakeup matrix scheduler.
// The per-entry record keeps the lifecycle flags and the execute latency;
// dependency rows and countdowns live beside it in the top module.
package wakeup_matrix_sched_pkg;

    localparam int WAKEUP_LAT_W = 4;
    localparam int MAX_ENTRIES  = 64;
    localparam int MAX_IDX_W    = $clog2(MAX_ENTRIES);

    typedef struct packed {
        logic                    valid;
        logic                    issued;
        logic [WAKEUP_LAT_W-1:0] lat;
    } sched_entry_t;

    // Lowest set bit of a free vector; returns 0 when nothing is free.
    function automatic logic [MAX_IDX_W-1:0] priority_lowest_free(
        input logic [MAX_ENTRIES-1:0] free_vec
    );
        logic [MAX_IDX_W-1:0] idx;
        logic                 found;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < MAX_ENTRIES; i++) begin
            if (free_vec[i] && !found) begin
                idx   = MAX_IDX_W'(i);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/wakeup_matrix_sched_if.sv
// Dispatch / select / flush bundle between the rename-dispatch stage, the
// select logic and the wakeup matrix. The scheduler uses the slave modport.
// bcast_vec exists only when WAKEUP_BCAST_OUT_EN is defined.
interface wakeup_matrix_sched_if #(
    parameter int NUM_ENTRIES = 8,
    parameter int NUM_GRANTS  = 2,
    parameter int LAT_W       = 4
);
    localparam int IDX_W = $clog2(NUM_ENTRIES);

    logic                        disp_valid;
    logic                        disp_ready;
    logic [IDX_W-1:0]            disp_idx;
    logic [NUM_ENTRIES-1:0]      disp_dep_vec;
    logic [LAT_W-1:0]            disp_latency;
    logic [NUM_GRANTS-1:0]       grant_valid;
    logic [NUM_GRANTS*IDX_W-1:0] grant_idx;
    logic                        flush;
    logic [NUM_ENTRIES-1:0]      request_vector;
    logic [IDX_W:0]              free_count;
`ifdef WAKEUP_BCAST_OUT_EN
    logic [NUM_ENTRIES-1:0]      bcast_vec;
`endif

    modport master (
        output disp_valid, disp_dep_vec, disp_latency, grant_valid, grant_idx, flush,
        input  disp_ready, disp_idx, request_vector, free_count
`ifdef WAKEUP_BCAST_OUT_EN
        , input bcast_vec
`endif
    );

    modport slave (
        input  disp_valid, disp_dep_vec, disp_latency, grant_valid, grant_idx, flush,
        output disp_ready, disp_idx, request_vector, free_count
`ifdef WAKEUP_BCAST_OUT_EN
        , output bcast_vec
`endif
    );

endinterface

// File: rtl/wakeup_matrix_sched_lat_counter.sv
// Per-entry execute-latency countdown. Loaded with lat-1 when a multi-cycle
// op is granted; fire_o is high during the cycle whose closing edge must
// broadcast the entry's column, after which the counter rests at zero.
module wakeup_lat_counter #(
    parameter int LAT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             load_i,
    input  logic [LAT_W-1:0] load_val_i,
    output logic             fire_o
);

    logic [LAT_W-1:0] cnt_q;
    logic [LAT_W-1:0] cnt_d;

    // Flush drops the countdown, a grant loads it, otherwise count down to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (flush_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - LAT_W'(1);
        end
    end

    // Counter register, cleared asynchronously so a reset discards pending wakeups.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign fire_o = (cnt_q == LAT_W'(1));

endmodule

// File: rtl/wakeup_matrix_sched.sv
// Issue-queue wakeup core: dependency matrix, per-entry latency countdown and
// lowest-index free-entry allocation. Granted entries clear their column in
// every dependency row after their execute latency and free their slot.
// Optional: define WAKEUP_BCAST_OUT_EN to export the broadcast vector.
module wakeup_matrix_sched
    import wakeup_matrix_sched_pkg::*;
#(
    parameter int NUM_ENTRIES = 8,
    parameter int NUM_GRANTS  = 2,
    parameter int LAT_W       = WAKEUP_LAT_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    wakeup_matrix_sched_if.slave  bus
);

    localparam int IDX_W = $clog2(NUM_ENTRIES);

    sched_entry_t           entry_q [NUM_ENTRIES];
    sched_entry_t           entry_d [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] dep_q   [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] dep_d   [NUM_ENTRIES];
    logic [LAT_W-1:0]       load_val[NUM_ENTRIES];

    logic [NUM_ENTRIES-1:0] valid_vec;
    logic [NUM_ENTRIES-1:0] free_vec;
    logic [NUM_ENTRIES-1:0] request_vec;
    logic [NUM_ENTRIES-1:0] grant_raw;
    logic [NUM_ENTRIES-1:0] grant_hit;
    logic [NUM_ENTRIES-1:0] imm_bcast;
    logic [NUM_ENTRIES-1:0] cnt_load;
    logic [NUM_ENTRIES-1:0] cnt_fire;
    logic [NUM_ENTRIES-1:0] bcast;
    logic [IDX_W-1:0]       free_idx;
    logic [IDX_W:0]         free_cnt;
    logic                   accept;

    // Status derived purely from registered state: occupancy, readiness, free count.
    always_comb begin
        free_cnt = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            valid_vec[i]   = entry_q[i].valid;
            request_vec[i] = entry_q[i].valid & ~entry_q[i].issued & (dep_q[i] == '0);
            free_cnt       = free_cnt + {{IDX_W{1'b0}}, ~entry_q[i].valid};
        end
        free_vec = ~valid_vec;
        free_idx = IDX_W'(priority_lowest_free(MAX_ENTRIES'(free_vec)));
    end

    // Decode grant ports; a grant counts only for a requesting entry and duplicates merge.
    always_comb begin
        grant_raw = '0;
        for (int p = 0; p < NUM_GRANTS; p++) begin
            if (bus.grant_valid[p]) begin
                grant_raw[bus.grant_idx[p*IDX_W +: IDX_W]] = 1'b1;
            end
        end
        grant_hit = grant_raw & request_vec & {NUM_ENTRIES{~bus.flush}};
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            imm_bcast[i] = grant_hit[i] & (LAT_W'(entry_q[i].lat) <= LAT_W'(1));
            cnt_load[i]  = grant_hit[i] & (LAT_W'(entry_q[i].lat) >  LAT_W'(1));
            load_val[i]  = LAT_W'(entry_q[i].lat) - LAT_W'(1);
        end
    end

    assign bcast  = imm_bcast | cnt_fire;
    assign accept = bus.disp_valid & (|free_vec) & ~bus.flush;

    // Next-state per entry: issue, column clear and free, dispatch write, flush last.
    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            entry_d[i] = entry_q[i];
            dep_d[i]   = dep_q[i] & ~bcast;
            if (grant_hit[i]) begin
                entry_d[i].issued = 1'b1;
            end
            if (bcast[i]) begin
                entry_d[i].valid  = 1'b0;
                entry_d[i].issued = 1'b0;
            end
            if (accept && (free_idx == IDX_W'(i))) begin
                entry_d[i].valid  = 1'b1;
                entry_d[i].issued = 1'b0;
                entry_d[i].lat    = WAKEUP_LAT_W'(bus.disp_latency);
                dep_d[i]          = bus.disp_dep_vec & valid_vec & ~bcast;
            end
            if (bus.flush) begin
                entry_d[i] = '0;
                dep_d[i]   = '0;
            end
        end
    end

    // Entry and matrix registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                entry_q[i] <= '0;
                dep_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                entry_q[i] <= entry_d[i];
                dep_q[i]   <= dep_d[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_cnt
        wakeup_lat_counter #(
            .LAT_W (LAT_W)
        ) u_cnt (
            .clk        (clk),
            .rst_n      (rst_n),
            .flush_i    (bus.flush),
            .load_i     (cnt_load[g]),
            .load_val_i (load_val[g]),
            .fire_o     (cnt_fire[g])
        );
    end

    assign bus.request_vector = request_vec;
    assign bus.disp_ready     = |free_vec;
    assign bus.disp_idx       = free_idx;
    assign bus.free_count     = free_cnt;
`ifdef WAKEUP_BCAST_OUT_EN
    assign bus.bcast_vec      = bus.flush ? '0 : bcast;
`endif

endmodule

// File: tb/tb_wakeup_matrix_sched.sv
// Bench for wakeup_matrix_sched: directed scenarios plus randomized traffic,
// all checked against a per-entry model that tracks the absolute cycle at
// which each issued entry broadcasts.
module tb_wakeup_matrix_sched;

    localparam int NE = 8;
    localparam int NG = 2;
    localparam int LW = 4;
    localparam int IW = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    wakeup_matrix_sched_if #(.NUM_ENTRIES(NE), .NUM_GRANTS(NG), .LAT_W(LW)) bus ();

    wakeup_matrix_sched #(
        .NUM_ENTRIES (NE),
        .NUM_GRANTS  (NG),
        .LAT_W       (LW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checkCount = 0;
    int passCount  = 0;
    int cyc = 0;

    bit            mValid [NE];
    bit            mIssued[NE];
    logic [NE-1:0] mDep   [NE];
    int            mLat   [NE];
    int            mDue   [NE];

    // Compare one observed value to its expectation and tally the result.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected)
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, actual, expected, cyc);
        else
            passCount++;
    endtask

    task automatic modelReset();
        for (int i = 0; i < NE; i++) begin
            mValid[i] = 0; mIssued[i] = 0; mDep[i] = '0; mLat[i] = 0; mDue[i] = -1;
        end
    endtask

    function automatic logic [NE-1:0] modelRequest();
        logic [NE-1:0] r;
        for (int i = 0; i < NE; i++) r[i] = mValid[i] && !mIssued[i] && (mDep[i] == '0);
        return r;
    endfunction

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "Req"},   32'(bus.request_vector), 32'h0);
        checkOutput({tag, "Ready"}, 32'(bus.disp_ready), 32'h1);
        checkOutput({tag, "Idx"},   32'(bus.disp_idx), 32'h0);
        checkOutput({tag, "Free"},  32'(bus.free_count), 32'(NE));
`ifdef WAKEUP_BCAST_OUT_EN
        checkOutput({tag, "Bcast"}, 32'(bus.bcast_vec), 32'h0);
`endif
    endtask

    // Drive one cycle of inputs, check outputs mid-cycle, then advance the model.
    task automatic applyStimulus(input bit dv, input logic [NE-1:0] dep, input logic [LW-1:0] lat,
                                 input logic [NG-1:0] gv, input logic [NG*IW-1:0] gi, input bit fl);
        logic [NE-1:0] req, g, bc, validPre;
        int freeIdx, freeCnt, e, L;
        bus.disp_valid = dv; bus.disp_dep_vec = dep; bus.disp_latency = lat;
        bus.grant_valid = gv; bus.grant_idx = gi; bus.flush = fl;
        req = modelRequest();
        freeIdx = -1; freeCnt = 0;
        for (int i = 0; i < NE; i++) begin
            validPre[i] = mValid[i];
            if (!mValid[i]) begin
                freeCnt++;
                if (freeIdx < 0) freeIdx = i;
            end
        end
        g = '0; bc = '0;
        for (int p = 0; p < NG; p++) begin
            e = int'(gi[p*IW +: IW]);
            if (gv[p] && req[e]) g[e] = 1'b1;
        end
        for (int i = 0; i < NE; i++) begin
            L = (mLat[i] == 0) ? 1 : mLat[i];
            if (mValid[i] && mIssued[i] && mDue[i] == cyc) bc[i] = 1'b1;
            if (g[i] && L == 1) bc[i] = 1'b1;
        end
        @(negedge clk);
        checkOutput("req",   32'(bus.request_vector), 32'(req));
        checkOutput("ready", 32'(bus.disp_ready), 32'(freeCnt > 0));
        checkOutput("free",  32'(bus.free_count), 32'(freeCnt));
        if (freeCnt > 0) checkOutput("idx", 32'(bus.disp_idx), 32'(freeIdx));
`ifdef WAKEUP_BCAST_OUT_EN
        checkOutput("bcast", 32'(bus.bcast_vec), fl ? 32'h0 : 32'(bc));
`endif
        if (fl) begin
            modelReset();
        end else begin
            for (int i = 0; i < NE; i++) begin
                L = (mLat[i] == 0) ? 1 : mLat[i];
                if (g[i]) begin
                    mIssued[i] = 1;
                    if (L > 1) mDue[i] = cyc + L - 1;
                end
            end
            for (int i = 0; i < NE; i++) begin
                if (bc[i]) begin mValid[i] = 0; mIssued[i] = 0; mDue[i] = -1; end
                mDep[i] = mDep[i] & ~bc;
            end
            if (dv && freeCnt > 0) begin
                mValid[freeIdx] = 1; mIssued[freeIdx] = 0; mLat[freeIdx] = int'(lat);
                mDep[freeIdx] = dep & validPre & ~bc; mDue[freeIdx] = -1;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle();
        applyStimulus(0, '0, '0, '0, '0, 0);
    endtask

    task automatic dispatch(input logic [NE-1:0] dep, input logic [LW-1:0] lat);
        applyStimulus(1, dep, lat, '0, '0, 0);
    endtask

    task automatic grant2(input logic [NG-1:0] gv, input int a, input int b);
        applyStimulus(0, '0, '0, gv, {IW'(b), IW'(a)}, 0);
    endtask

    task automatic flushAll();
        applyStimulus(0, '0, '0, '0, '0, 1);
    endtask

    initial begin
        logic [NE-1:0] req;
        int q[$];
        logic [NG-1:0] gv;
        logic [NG*IW-1:0] gi;

        bus.disp_valid = 0; bus.disp_dep_vec = '0; bus.disp_latency = '0;
        bus.grant_valid = '0; bus.grant_idx = '0; bus.flush = 0;
        modelReset();

        // Reset values while reset is held.
        #12;
        checkResetOutputs("rst");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Fill all entries; allocation goes 0..7 in order.
        for (int i = 0; i < NE; i++) begin
            checkOutput("dispIdxSeq", 32'(bus.disp_idx), 32'(i));
            dispatch('0, 4'd1);
        end
        checkOutput("fullReady", 32'(bus.disp_ready), 32'h0);
        checkOutput("fullFree",  32'(bus.free_count), 32'h0);
        checkOutput("fullReq",   32'(bus.request_vector), 32'hFF);
        dispatch(8'h00, 4'd2);
        checkOutput("fullNoAccept", 32'(bus.free_count), 32'h0);
        flushAll();

        // Producer lat=3, consumer waits on it: consumer requests exactly 3 cycles after grant.
        dispatch('0, 4'd3);
        dispatch(8'h01, 4'd1);
        grant2(2'b01, 0, 0);
        checkOutput("prodT1", 32'(bus.request_vector[1]), 32'h0);
        idle();
        checkOutput("prodT2", 32'(bus.request_vector[1]), 32'h0);
        idle();
        checkOutput("prodT3", 32'(bus.request_vector[1]), 32'h1);
        checkOutput("prodFreeT3", 32'(bus.free_count), 32'd7);
        flushAll();

        // Consumer dispatched on the same edge its producer broadcasts.
        dispatch('0, 4'd1);
        dispatch('0, 4'd1);
        dispatch('0, 4'd1);
        applyStimulus(1, 8'h04, 4'd1, 2'b01, {3'd0, 3'd2}, 0);
        checkOutput("sameEdgeReq",  32'(bus.request_vector[3]), 32'h1);
        checkOutput("sameEdgeFree", 32'(bus.free_count), 32'd5);
        flushAll();

        // Two grants in one cycle, then a duplicated grant index.
        for (int i = 0; i < 6; i++) dispatch('0, (i == 3) ? 4'd1 : (i == 5) ? 4'd2 : 4'd4);
        dispatch(8'h28, 4'd1);
        grant2(2'b11, 3, 5);
        checkOutput("dualT1", 32'(bus.request_vector[6]), 32'h0);
        idle();
        checkOutput("dualT2", 32'(bus.request_vector[6]), 32'h1);
        grant2(2'b11, 0, 0);
        checkOutput("dupIssued", 32'(bus.request_vector[0]), 32'h0);
        for (int i = 0; i < 4; i++) idle();
        flushAll();

        // Flush with live countdowns and a simultaneous dispatch.
        for (int i = 0; i < 5; i++) dispatch('0, 4'd6);
        grant2(2'b11, 0, 1);
        idle();
        applyStimulus(1, '0, 4'd1, 2'b01, {3'd0, 3'd2}, 1);
        checkOutput("flushFree",  32'(bus.free_count), 32'(NE));
        checkOutput("flushReq",   32'(bus.request_vector), 32'h0);
        checkOutput("flushReady", 32'(bus.disp_ready), 32'h1);
        for (int i = 0; i < 8; i++) idle();

        // Asynchronous reset between edges while countdowns are pending.
        for (int i = 0; i < 3; i++) dispatch(8'h00, 4'd7);
        dispatch(8'h03, 4'd1);
        grant2(2'b11, 0, 1);
        idle();
        #2 rst_n = 1'b0;
        #1 checkResetOutputs("asyncRst");
        @(posedge clk);
        #1 checkResetOutputs("asyncRstHeld");
        #2 rst_n = 1'b1;
        modelReset();
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) idle();

        // Randomized traffic with occasional flush.
        for (int n = 0; n < 600; n++) begin
            req = modelRequest();
            q.delete();
            for (int i = 0; i < NE; i++) if (req[i]) q.push_back(i);
            gv = '0; gi = '0;
            for (int p = 0; p < NG; p++) begin
                if ($urandom_range(0, 99) < 60) begin
                    gv[p] = 1'b1;
                    if (q.size() > 0 && $urandom_range(0, 99) < 80)
                        gi[p*IW +: IW] = IW'(q[$urandom_range(0, q.size() - 1)]);
                    else
                        gi[p*IW +: IW] = IW'($urandom_range(0, NE - 1));
                end
            end
            applyStimulus($urandom_range(0, 99) < 55, NE'($urandom()), LW'($urandom_range(0, 6)),
                          gv, gi, $urandom_range(0, 99) < 2);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    // Watchdog so the run always ends even if something stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
